stream_pkt_chk: RTL
===================

Name: stream_pkt_chk

Overview:
- Synthesizable AXI-Stream packet sink and checker that sits in the CL as the receive end of a stream interface.
- Accepts packets whose payload follows the incrementing-DW pattern produced by the stream generator/BFM. Checks the data pattern, keep legality and length.
- Exposes packet/error counters and first-error capture for polling by the test or host.
- Optional LFSR-driven backpressure exercises the upstream transmitter.

Parameters:
- DATA_WIDTH, 512, stream data bus width (multiple of 32).
- KEEP_WIDTH, DATA_WIDTH/8, byte enables (bytes per beat).
- USER_WIDTH, 64, sideband width (sampled, not checked).
- CNT_WIDTH, 32, width of status counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- ins_data  in  DATA_WIDTH  stream data, byte j at [8j+:8].
- ins_keep  in  KEEP_WIDTH  byte valid.
- ins_valid  in  1  beat valid.
- ins_last  in  1  final beat of packet.
- ins_user  in  USER_WIDTH  sideband; captured on last beat into last_user.
- ins_ready  out  1  beat accept.
- cfg_en  in  1  checker enable; 0 holds ins_ready low.
- cfg_bp_en  in  1  enable pseudo-random backpressure.
- cfg_stop_on_err  in  1  halt after first errored packet.
- cfg_exp_len  in  16  expected byte length; 0 = length unchecked.
- cfg_clr  in  1  one-cycle pulse: clear counters, sticky error, HALT.
- pkt_cnt  out  CNT_WIDTH  packets completed.
- err_cnt  out  CNT_WIDTH  packets with at least one error.
- err_sticky  out  1  any error since reset/clear.
- first_err_type  out  3  bit0 DATA, bit1 KEEP, bit2 LEN, for the first errored packet.
- first_err_pkt  out  CNT_WIDTH  pkt_cnt value of the first errored packet.
- last_user  out  USER_WIDTH  ins_user from the most recent last beat.

Behaviour:
- Reset: all outputs 0, ins_ready 0, FSM IDLE, LFSR = 16'hACE1.
- Handshake: a beat is accepted on a rising clk edge with ins_valid & ins_ready. ins_ready is a register with no combinational path from ins_valid.
  - ins_ready = cfg_en & (state != HALT) & !(cfg_bp_en & lfsr[1:0]==2'b00).
  - LFSR: x^16+x^14+x^13+x^11+1, advances every cycle.
- FSM:
  - IDLE -> IN_PKT on an accepted beat with !ins_last. A single-beat packet stays in IDLE.
  - IN_PKT -> IDLE on an accepted last beat.
  - Any state -> HALT when a verdict has error & cfg_stop_on_err.
  - HALT -> IDLE on cfg_clr.
- Pattern:
  - start = first beat DW0 (bytes with keep=1 only; missing bytes treated as 0).
  - Expected DW at beat b, lane k = start + b*(KEEP_WIDTH/4) + k, mod 2^32, little-endian bytes.
  - Only bytes with keep=1 are compared.
  - Beat index b resets on first beat and counts to 2^16-1; it does not wrap within a legal packet.
- KEEP error: a non-last beat keep != all ones; or a last beat keep == 0 or not of the form 2^n-1 (non-contiguous or not starting at lane 0).
- LEN error: cfg_exp_len != 0 and accumulated byte count != cfg_exp_len. The byte count is popcount(keep) summed over beats and saturates at 2^16-1.
- Error flags accumulate across a packet's beats.
- Verdict latency: the per-beat compare result is registered. Counters, sticky error, first_err_* and last_user update exactly 2 cycles after the last-beat handshake.
  - pkt_cnt always increments; err_cnt increments by 1 if any flag is set.
  - first_err_* is written only when err_sticky was 0.
- Counters saturate at all ones.
- cfg_clr has priority: in-flight verdicts in the pipeline are discarded and the cycle's clear wins. A partial packet in IN_PKT continues to be checked; its verdict counts.
- Reset mid-packet: partial packet discarded, no verdict.
- cfg_en deasserted mid-packet: ins_ready low, state retained, checking resumes when re-enabled.
- cfg_* are quasi-static except cfg_clr. cfg_exp_len is sampled at the last beat.

Decomposition:
- Package stream_chk_pkg:
  - error bit positions ERR_DATA=0, ERR_KEEP=1, ERR_LEN=2.
  - FSM state enum {IDLE, IN_PKT, HALT}.
  - LFSR_SEED 16'hACE1 and LFSR taps.
- Sub-module stream_chk_beat_cmp: combinational per-beat compare.
  - Inputs: data, keep, start, beat index, last.
  - Outputs: data_err, keep_err, byte popcount.
- The top holds the FSM, LFSR, accumulators and pipeline registers.

Test Plan:
- Single 64-byte packet, start 32'h1000_0000, keep all ones, last -> pkt_cnt=1, err_cnt=0, err_sticky=0 two cycles after handshake.
- 130-byte packet, cfg_exp_len=130 -> 3 beats, last keep=64'h3, DW 32 = 32'h1000_0020, no error. Repeat with cfg_exp_len=100 -> err_cnt=1, first_err_type=3'b100, first_err_pkt=0.
- Packets 0..4 with byte 70 of packet 3 flipped -> err_cnt=1, first_err_type=3'b001, first_err_pkt=3, pkt_cnt=5.
- Middle beat keep=64'hFFFF_FFFF_FFFF_FFFE with cfg_stop_on_err=1 -> first_err_type=3'b010, FSM HALT, ins_ready stays 0. cfg_clr -> counters 0, ins_ready returns 1.
- cfg_bp_en=1, 200 random-length packets (1..1000 bytes) -> ins_ready low on ~25% of cycles, pkt_cnt=200, err_cnt=0, no beat accepted while ins_ready=0.
- rst_n low mid-packet for 1 cycle, then a fresh 64-byte packet -> all outputs 0 during reset, pkt_cnt=1, err_cnt=0. cfg_clr coincident with a last beat -> pkt_cnt=0 afterwards.

Source files
------------

// File: rtl/stream_chk_pkg.sv
// Shared definitions for the AXI-Stream packet checker: error bit positions,
// FSM states and the backpressure LFSR.
package stream_chk_pkg;

  localparam int ERR_DATA = 0;
  localparam int ERR_KEEP = 1;
  localparam int ERR_LEN  = 2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    HALT
  } chk_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/stream_chk_beat_cmp.sv
// Combinational check of one stream beat against the incrementing-DW pattern,
// plus keep legality and the number of valid bytes in the beat.
module stream_chk_beat_cmp
  import stream_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [KEEP_WIDTH-1:0] keep,
  input  logic [31:0]           start,
  input  logic [15:0]           beat_idx,
  input  logic                  last,
  output logic                  data_err,
  output logic                  keep_err,
  output logic [15:0]           byte_cnt
);

  localparam int LANES = KEEP_WIDTH / 4;

  logic [31:0]           beat_base;
  logic [LANES-1:0]      lane_err;
  logic [KEEP_WIDTH-1:0] keep_inc;

  assign beat_base = start + 32'(beat_idx) * 32'(LANES);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [31:0] exp_dw;
      logic [31:0] byte_mask;
      assign exp_dw = beat_base + 32'(gi);
      for (genvar gj = 0; gj < 4; gj++) begin : g_byte
        assign byte_mask[8*gj +: 8] = {8{keep[4*gi+gj]}};
      end
      assign lane_err[gi] = |((data[32*gi +: 32] ^ exp_dw) & byte_mask);
    end
  endgenerate

  assign data_err = |lane_err;

  // A legal last-beat keep is 2^n-1 (n>=1): contiguous from lane 0
  assign keep_inc = keep + KEEP_WIDTH'(1);
  assign keep_err = last ? ((keep == '0) || ((keep & keep_inc) != '0))
                         : (keep != '1);

  always_comb begin
    byte_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      byte_cnt = byte_cnt + 16'(keep[i]);
    end
  end

endmodule

// File: rtl/stream_pkt_chk.sv
// AXI-Stream packet sink: checks payload pattern, keep and length, and keeps
// polled status counters with first-error capture and optional backpressure.
module stream_pkt_chk
  import stream_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ins_data,
  input  logic [KEEP_WIDTH-1:0] ins_keep,
  input  logic                  ins_valid,
  input  logic                  ins_last,
  input  logic [USER_WIDTH-1:0] ins_user,
  output logic                  ins_ready,
  input  logic                  cfg_en,
  input  logic                  cfg_bp_en,
  input  logic                  cfg_stop_on_err,
  input  logic [15:0]           cfg_exp_len,
  input  logic                  cfg_clr,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  err_sticky,
  output logic [2:0]            first_err_type,
  output logic [CNT_WIDTH-1:0]  first_err_pkt,
  output logic [USER_WIDTH-1:0] last_user
);

  chk_state_e state_reg, state_next;
  logic [15:0] lfsr_reg, lfsr_next;
  logic        ready_reg, ready_next;

  logic        hs, first_beat;
  logic [31:0] start_reg, start_first, start_cur;
  logic [15:0] beat_idx_reg, beat_idx_cur;
  logic        beat_data_err, beat_keep_err;
  logic [15:0] beat_bytes;

  logic                  s1_valid_reg, s1_first_reg, s1_last_reg;
  logic                  s1_data_err_reg, s1_keep_err_reg;
  logic [15:0]           s1_bytes_reg, s1_exp_len_reg;
  logic [USER_WIDTH-1:0] s1_user_reg;

  logic [2:0]  acc_flags_reg, acc_flags_next, verdict_flags_next;
  logic [15:0] acc_bytes_reg, acc_bytes_next;
  logic [16:0] bytes_sum;
  logic        len_err;

  logic                  v_valid_reg;
  logic [2:0]            v_flags_reg;
  logic [USER_WIDTH-1:0] v_user_reg;
  logic                  verdict_err;

  logic [CNT_WIDTH-1:0]  pkt_cnt_reg, err_cnt_reg, first_err_pkt_reg;
  logic                  err_sticky_reg;
  logic [2:0]            first_err_type_reg;
  logic [USER_WIDTH-1:0] last_user_reg;

  assign hs         = ins_valid && ready_reg;
  assign first_beat = (state_reg != IN_PKT);

  // Pattern start is DW0 of the first beat with unkept bytes forced to zero
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_start
      assign start_first[8*gi +: 8] = ins_data[8*gi +: 8] & {8{ins_keep[gi]}};
    end
  endgenerate

  assign start_cur    = first_beat ? start_first : start_reg;
  assign beat_idx_cur = first_beat ? 16'd0 : beat_idx_reg;

  stream_chk_beat_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_beat_cmp (
    .data     (ins_data),
    .keep     (ins_keep),
    .start    (start_cur),
    .beat_idx (beat_idx_cur),
    .last     (ins_last),
    .data_err (beat_data_err),
    .keep_err (beat_keep_err),
    .byte_cnt (beat_bytes)
  );

  assign verdict_err = v_valid_reg && (v_flags_reg != 3'b000) && !cfg_clr;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hs && !ins_last) state_next = IN_PKT;
      IN_PKT:  if (hs && ins_last)  state_next = IDLE;
      HALT:    if (cfg_clr)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (verdict_err && cfg_stop_on_err) state_next = HALT;
  end

  // Ready is computed from next-cycle state so HALT blocks beats immediately
  assign lfsr_next  = lfsr_step(lfsr_reg);
  assign ready_next = cfg_en && (state_next != HALT) &&
                      !(cfg_bp_en && (lfsr_next[1:0] == 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lfsr_reg  <= LFSR_SEED;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      ready_reg <= ready_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_reg       <= '0;
      beat_idx_reg    <= '0;
      s1_valid_reg    <= 1'b0;
      s1_first_reg    <= 1'b0;
      s1_last_reg     <= 1'b0;
      s1_data_err_reg <= 1'b0;
      s1_keep_err_reg <= 1'b0;
      s1_bytes_reg    <= '0;
      s1_exp_len_reg  <= '0;
      s1_user_reg     <= '0;
    end else begin
      // A last beat accepted together with a clear never yields a verdict
      s1_valid_reg <= hs && !(cfg_clr && ins_last);
      if (hs) begin
        if (first_beat) start_reg <= start_first;
        beat_idx_reg    <= (beat_idx_cur == 16'hFFFF) ? 16'hFFFF : beat_idx_cur + 16'd1;
        s1_first_reg    <= first_beat;
        s1_last_reg     <= ins_last;
        s1_data_err_reg <= beat_data_err;
        s1_keep_err_reg <= beat_keep_err;
        s1_bytes_reg    <= beat_bytes;
        s1_exp_len_reg  <= cfg_exp_len;
        s1_user_reg     <= ins_user;
      end
    end
  end

  always_comb begin
    acc_flags_next           = s1_first_reg ? 3'b000 : acc_flags_reg;
    acc_flags_next[ERR_DATA] = acc_flags_next[ERR_DATA] | s1_data_err_reg;
    acc_flags_next[ERR_KEEP] = acc_flags_next[ERR_KEEP] | s1_keep_err_reg;
    bytes_sum      = {1'b0, (s1_first_reg ? 16'd0 : acc_bytes_reg)} + {1'b0, s1_bytes_reg};
    acc_bytes_next = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
    len_err        = (s1_exp_len_reg != 16'd0) && (acc_bytes_next != s1_exp_len_reg);
    verdict_flags_next          = acc_flags_next;
    verdict_flags_next[ERR_LEN] = len_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_flags_reg <= '0;
      acc_bytes_reg <= '0;
      v_valid_reg   <= 1'b0;
      v_flags_reg   <= '0;
      v_user_reg    <= '0;
    end else begin
      v_valid_reg <= s1_valid_reg && s1_last_reg && !cfg_clr;
      if (s1_valid_reg) begin
        acc_flags_reg <= acc_flags_next;
        acc_bytes_reg <= acc_bytes_next;
        if (s1_last_reg) begin
          v_flags_reg <= verdict_flags_next;
          v_user_reg  <= s1_user_reg;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_reg        <= '0;
      err_cnt_reg        <= '0;
      err_sticky_reg     <= 1'b0;
      first_err_type_reg <= '0;
      first_err_pkt_reg  <= '0;
      last_user_reg      <= '0;
    end else if (cfg_clr) begin
      pkt_cnt_reg        <= '0;
      err_cnt_reg        <= '0;
      err_sticky_reg     <= 1'b0;
      first_err_type_reg <= '0;
      first_err_pkt_reg  <= '0;
    end else if (v_valid_reg) begin
      last_user_reg <= v_user_reg;
      if (pkt_cnt_reg != '1) pkt_cnt_reg <= pkt_cnt_reg + CNT_WIDTH'(1);
      if (v_flags_reg != 3'b000) begin
        if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
        err_sticky_reg <= 1'b1;
        if (!err_sticky_reg) begin
          first_err_type_reg <= v_flags_reg;
          first_err_pkt_reg  <= pkt_cnt_reg;
        end
      end
    end
  end

  assign ins_ready      = ready_reg;
  assign pkt_cnt        = pkt_cnt_reg;
  assign err_cnt        = err_cnt_reg;
  assign err_sticky     = err_sticky_reg;
  assign first_err_type = first_err_type_reg;
  assign first_err_pkt  = first_err_pkt_reg;
  assign last_user      = last_user_reg;

endmodule
